window_slide_sequencer: RTL and testbench

WINDOW_SLIDE_SEQUENCER -- requirements
Module: window_slide_sequencer

---
 rtl/window_slide_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_window_slide_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_slide_sequencer.sv
// rtl/window_slide_sequencer.sv - sequences a window-slide wrapper and buffers its windows for a downstream consumer
//
// Drives one frame through the wrapper: a start strobe, then one slide per
// window, never more than one request outstanding.  Each window is tagged with
// its raster index and queued in a small FIFO; a slide is only issued while
// the FIFO has room, so a push can never land in a full FIFO.
//
// Optional feature: define WS_SEQ_STALL_CNT_EN to build the stall counter.
//
// Ports
//   clk          in   clock, all state changes on posedge
//   rst          in   synchronous active-low reset
//   frame_start  in   request one frame (honoured only in IDLE)
//   frame_abort  in   synchronous abort, highest priority
//   frame_busy   out  high whenever not IDLE
//   frame_done   out  one-cycle pulse once all windows have left the FIFO
//   ws_start     out  start strobe to wrapper
//   ws_slide     out  slide request to wrapper
//   ws_window    in   window bits from wrapper
//   ws_valid     in   wrapper window-valid strobe
//   m_valid      out  FIFO not empty
//   m_ready      in   downstream accept
//   m_window     out  FIFO head window
//   m_index      out  FIFO head raster index
//   stall_cycles out  stall counter (0 unless WS_SEQ_STALL_CNT_EN)

module window_slide_sequencer #(
   parameter int IMAGE_ROW_LEN = 32,
   parameter int IMAGE_COL_LEN = 32,
   parameter int KERNEL_SIZE   = 3,
   parameter int STRIDE        = 1,
   parameter int FIFO_DEPTH    = 4,
   localparam int NW = ((IMAGE_ROW_LEN - KERNEL_SIZE) / STRIDE + 1) *
                       ((IMAGE_COL_LEN - KERNEL_SIZE) / STRIDE + 1),
   localparam int IW = (NW > 1) ? $clog2(NW) : 1,
   localparam int WW = KERNEL_SIZE * KERNEL_SIZE
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          frame_start,
   input  logic          frame_abort,
   output logic          frame_busy,
   output logic          frame_done,
   output logic          ws_start,
   output logic          ws_slide,
   input  logic [WW-1:0] ws_window,
   input  logic          ws_valid,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [WW-1:0] m_window,
   output logic [IW-1:0] m_index,
   output logic [31:0]   stall_cycles
);

   localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [IW-1:0] LAST_C  = IW'(NW - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_START    = 3'd1,
      S_WAIT_WIN = 3'd2,
      S_SLIDE    = 3'd3,
      S_DRAIN    = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] wcnt_q, wcnt_d;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [WW-1:0] win_mem_q [FIFO_DEPTH];
   logic [IW-1:0] idx_mem_q [FIFO_DEPTH];

   logic fifo_empty;
   logic fifo_full;
   logic push;
   logic pop;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == DEPTH_C);

   // Abort outranks a window arriving in the same cycle.
   assign push = (state_q == S_WAIT_WIN) && ws_valid && !frame_abort;
   assign pop  = !fifo_empty && m_ready;

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         wcnt_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the head is masked to zero while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         win_mem_q[wr_ptr_q] <= ws_window;
         idx_mem_q[wr_ptr_q] <= wcnt_q;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      if (frame_abort) begin
         state_d = S_IDLE;
         wcnt_d  = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (frame_start) begin
                  state_d = S_START;
                  wcnt_d  = '0;
               end
            end
            S_START: state_d = S_WAIT_WIN;
            S_WAIT_WIN: begin
               if (ws_valid) begin
                  if (wcnt_q == LAST_C) begin
                     state_d = S_DRAIN;
                  end else begin
                     wcnt_d  = wcnt_q + IW'(1);
                     state_d = S_SLIDE;
                  end
               end
            end
            S_SLIDE: begin
               if (!fifo_full) state_d = S_WAIT_WIN;
            end
            S_DRAIN: begin
               if (fifo_empty) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (frame_abort) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Pointers wrap naturally because FIFO_DEPTH is a power of two.
         wr_ptr_d = wr_ptr_q + PW'(push);
         rd_ptr_d = rd_ptr_q + PW'(pop);
         count_d  = count_q + CW'(push) - CW'(pop);
      end
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      frame_busy = 1'b0;
      frame_done = 1'b0;
      ws_start   = 1'b0;
      ws_slide   = 1'b0;
      case (state_q)
         S_IDLE:     frame_busy = 1'b0;
         S_START: begin
            frame_busy = 1'b1;
            ws_start   = !frame_abort;
         end
         S_WAIT_WIN: frame_busy = 1'b1;
         S_SLIDE: begin
            frame_busy = 1'b1;
            // Suppressed on abort so the wrapper is not left with a stray request.
            ws_slide   = !fifo_full && !frame_abort;
         end
         S_DRAIN: begin
            frame_busy = 1'b1;
            frame_done = fifo_empty && !frame_abort;
         end
         default:    frame_busy = 1'b0;
      endcase
   end

   assign m_valid  = !fifo_empty;
   assign m_window = fifo_empty ? '0 : win_mem_q[rd_ptr_q];
   assign m_index  = fifo_empty ? '0 : idx_mem_q[rd_ptr_q];

`ifdef WS_SEQ_STALL_CNT_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if ((state_q == S_IDLE) && frame_start && !frame_abort) begin
         stall_d = '0;
      end else if ((((state_q == S_SLIDE) && fifo_full) || (m_valid && !m_ready)) &&
                   (stall_q != 32'hFFFF_FFFF)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_window_slide_sequencer.sv
// tb/tb_window_slide_sequencer.sv - self-checking bench for window_slide_sequencer

module tb_window_slide_sequencer;

   logic        clk;
   logic        rst;
   logic        frame_start;
   logic        frame_abort;
   logic        frame_busy;
   logic        frame_done;
   logic        ws_start;
   logic        ws_slide;
   logic [8:0]  ws_window;
   logic        ws_valid;
   logic        m_valid;
   logic        m_ready;
   logic [8:0]  m_window;
   logic [3:0]  m_index;
   logic [31:0] stall_cycles;

   window_slide_sequencer #(
      .IMAGE_ROW_LEN(5),
      .IMAGE_COL_LEN(5),
      .KERNEL_SIZE(3),
      .STRIDE(1),
      .FIFO_DEPTH(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .frame_start(frame_start),
      .frame_abort(frame_abort),
      .frame_busy(frame_busy),
      .frame_done(frame_done),
      .ws_start(ws_start),
      .ws_slide(ws_slide),
      .ws_window(ws_window),
      .ws_valid(ws_valid),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .m_window(m_window),
      .m_index(m_index),
      .stall_cycles(stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] idx;
      logic [8:0] win;
   } exp_t;

   typedef struct {
      int rmode;
      int exp_windows;
      int exp_slides;
      int exp_dones;
   } vec_t;

   exp_t sb_q[$];

   int total;
   int bad;
   int rmode;
   int cyc;
   int wdelay;
   int wnext;
   int valids;
   int delivered;
   int slides;
   int dones;
   logic want_start;
   logic want_abort;
   logic want_spur;

   function automatic logic [8:0] win_of(input int n);
      logic [8:0] v;
      v = 9'(n * 53 + 17) ^ 9'h0a5;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_counts();
      valids    = 0;
      delivered = 0;
      slides    = 0;
      dones     = 0;
   endtask

   // One clock: drive inputs just after posedge, observe on negedge.
   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      frame_start = want_start;
      frame_abort = want_abort;
      want_start  = 1'b0;
      want_abort  = 1'b0;
      case (rmode)
         0:       m_ready = 1'b0;
         1:       m_ready = 1'b1;
         2:       m_ready = cyc[0];
         3:       m_ready = ((cyc % 3) == 0);
         default: m_ready = (delivered < 3);
      endcase
      cyc++;
      ws_valid  = 1'b0;
      ws_window = '0;
      if (want_spur) begin
         ws_valid  = 1'b1;
         ws_window = 9'h1ff;
         want_spur = 1'b0;
      end else if (wdelay > 0) begin
         wdelay--;
         if (wdelay == 0) begin
            ws_valid  = 1'b1;
            ws_window = win_of(wnext);
            e.idx     = 4'(wnext);
            e.win     = win_of(wnext);
            sb_q.push_back(e);
            valids++;
         end
      end
      @(negedge clk);
      if (!rst || frame_abort) begin
         sb_q.delete();
         wdelay = 0;
      end else begin
         if (m_valid && m_ready) begin
            if (sb_q.size() == 0) begin
               check("pop_has_expected", 64'd0, 64'd1);
            end else begin
               e = sb_q.pop_front();
               check("pop_index", 64'(m_index), 64'(e.idx));
               check("pop_window", 64'(m_window), 64'(e.win));
            end
            delivered++;
         end
         if (ws_slide) slides++;
         if (frame_done) dones++;
         if (ws_start) begin
            wnext  = 0;
            wdelay = 3;
         end else if (ws_slide) begin
            wnext++;
            wdelay = 3;
         end
      end
   endtask

   task automatic run_to_done(input int budget);
      int n;
      n = 0;
      while (dones == 0 && n < budget) begin
         step();
         n++;
      end
      check("done_within_budget", 64'(dones), 64'd1);
      repeat (10) step();
   endtask

   vec_t vecs[3];
   int   n;

   initial begin
      vecs[0] = '{1, 9, 8, 1};
      vecs[1] = '{2, 9, 8, 1};
      vecs[2] = '{3, 9, 8, 1};

      total = 0;
      bad   = 0;
      cyc   = 0;
      wdelay = 0;
      wnext  = 0;
      rmode  = 1;
      want_start = 1'b0;
      want_abort = 1'b0;
      want_spur  = 1'b0;
      rst         = 1'b0;
      frame_start = 1'b0;
      frame_abort = 1'b0;
      ws_valid    = 1'b0;
      ws_window   = '0;
      m_ready     = 1'b0;
      clear_counts();

      // Reset state
      step();
      step();
      check("rst_busy", 64'(frame_busy), 64'd0);
      check("rst_done", 64'(frame_done), 64'd0);
      check("rst_ws_start", 64'(ws_start), 64'd0);
      check("rst_ws_slide", 64'(ws_slide), 64'd0);
      check("rst_m_valid", 64'(m_valid), 64'd0);
      check("rst_m_window", 64'(m_window), 64'd0);
      check("rst_m_index", 64'(m_index), 64'd0);
      check("rst_stall", 64'(stall_cycles), 64'd0);
      rst = 1'b1;
      step();

      // Start latency: ws_start one cycle after frame_start, exactly one cycle long
      clear_counts();
      rmode = 1;
      want_start = 1'b1;
      step();
      check("lat_ws_start_c0", 64'(ws_start), 64'd0);
      check("lat_busy_c0", 64'(frame_busy), 64'd0);
      step();
      check("lat_ws_start_c1", 64'(ws_start), 64'd1);
      check("lat_busy_c1", 64'(frame_busy), 64'd1);
      step();
      check("lat_ws_start_c2", 64'(ws_start), 64'd0);
      run_to_done(300);
      check("lat_frame_windows", 64'(delivered), 64'd9);

      // Table-driven full frames under different downstream patterns
      for (int i = 0; i < 3; i++) begin
         clear_counts();
         rmode = vecs[i].rmode;
         want_start = 1'b1;
         step();
         run_to_done(400);
         check("vec_windows", 64'(delivered), 64'(vecs[i].exp_windows));
         check("vec_slides", 64'(slides), 64'(vecs[i].exp_slides));
         check("vec_dones", 64'(dones), 64'(vecs[i].exp_dones));
         check("vec_busy_after", 64'(frame_busy), 64'd0);
         check("vec_sb_empty", 64'(sb_q.size()), 64'd0);
      end

      // Backpressure: FIFO fills to 4, slides stop, stall counter, spurious inputs
      clear_counts();
      rmode = 0;
      want_start = 1'b1;
      step();
      n = 0;
      while (valids < 1 && n < 50) begin
         step();
         n++;
      end
      check("bp_first_window", 64'(valids), 64'd1);
      step();
      repeat (20) step();
`ifdef WS_SEQ_STALL_CNT_EN
      check("bp_stall_cycles", 64'(stall_cycles), 64'd20);
`else
      check("bp_stall_cycles", 64'(stall_cycles), 64'd0);
`endif
      repeat (20) step();
      check("bp_pushes", 64'(valids), 64'd4);
      check("bp_slides", 64'(slides), 64'd3);
      check("bp_m_valid", 64'(m_valid), 64'd1);
      check("bp_head_index", 64'(m_index), 64'd0);
      check("bp_head_window", 64'(m_window), 64'(win_of(0)));
      want_spur = 1'b1;
      step();
      want_start = 1'b1;
      step();
      repeat (5) step();
      check("bp_busy_held", 64'(frame_busy), 64'd1);
      check("bp_ws_start_ignored", 64'(ws_start), 64'd0);
      rmode = 1;
      run_to_done(400);
      check("bp_windows", 64'(delivered), 64'd9);
      check("bp_slides_total", 64'(slides), 64'd8);
      check("bp_dones", 64'(dones), 64'd1);

      // Reset mid-frame discards buffered windows
      clear_counts();
      rmode = 0;
      want_start = 1'b1;
      step();
      repeat (12) step();
      check("mr_buffered", 64'(m_valid), 64'd1);
      rst = 1'b0;
      step();
      check("mr_m_valid", 64'(m_valid), 64'd0);
      check("mr_busy", 64'(frame_busy), 64'd0);
      check("mr_m_index", 64'(m_index), 64'd0);
      rst = 1'b1;
      step();

      // Abort after the 5th window with 2 buffered, then restart from index 0
      clear_counts();
      rmode = 4;
      want_start = 1'b1;
      step();
      n = 0;
      while (valids < 5 && n < 100) begin
         step();
         n++;
      end
      check("ab_five_windows", 64'(valids), 64'd5);
      step();
      check("ab_delivered", 64'(delivered), 64'd3);
      check("ab_m_valid_before", 64'(m_valid), 64'd1);
      want_abort = 1'b1;
      step();
      step();
      check("ab_m_valid_after", 64'(m_valid), 64'd0);
      check("ab_busy_after", 64'(frame_busy), 64'd0);
      repeat (10) step();
      check("ab_no_done", 64'(dones), 64'd0);
      clear_counts();
      rmode = 1;
      want_start = 1'b1;
      step();
      run_to_done(300);
      check("ab_restart_windows", 64'(delivered), 64'd9);
      check("ab_restart_dones", 64'(dones), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
